// File: rtl/seg7_scan_driver.sv
// Scans eight double-buffered hex digits onto a common-anode 8-digit 7-segment display.
// Latency: outputs lag the scan counters by one clock; no backpressure, load is always accepted (last load wins).
module seg7_scan_driver #(
    parameter int DIV   = 100000,
    parameter int BLANK = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [47:0] d_in,
    output logic [7:0]  an,
    output logic [7:0]  dec_ddp,
    output logic        frame_done,
    output logic        pending
);

    localparam int               CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

    // Active-low segment pattern {a,b,c,d,e,f,g} for one hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] hex);
        logic [6:0] s;
        case (hex)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Reset asserts asynchronously everywhere but releases only after two clean clock edges.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [47:0]      shadow_q, shadow_d;
    logic [47:0]      active_q, active_d;
    logic             pending_q, pending_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       dec_q, dec_d;
    logic             frame_done_q;
    logic             slot_end;
    logic             frame_end;
    logic [5:0]       digit_sel;
    logic             blank;

    always_comb begin
        slot_end  = (div_cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == 3'd7);
        div_cnt_d = slot_end ? '0 : div_cnt_q + CNT_W'(1);
        idx_d     = slot_end ? idx_q + 3'd1 : idx_q;
    end

    // The displayed word only changes at frame end, so a frame never mixes two words.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (frame_end) begin
            if (load) begin
                active_d  = d_in;
                shadow_d  = d_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (load) begin
            shadow_d  = d_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        digit_sel = '0;
        for (int k = 0; k < 8; k++) begin
            if (idx_q == 3'(k)) begin
                digit_sel = active_q[6*k +: 6];
            end
        end
        blank = (div_cnt_q < CNT_BLANK) || !digit_sel[5];
        an_d  = blank ? 8'hFF : ~(8'h01 << idx_q);
        dec_d = blank ? 8'hFF : {seg7(digit_sel[4:1]), ~digit_sel[0]};
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= 8'hFF;
            dec_q        <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            dec_q        <= dec_d;
            frame_done_q <= frame_end;
        end
    end

    assign an         = an_q;
    assign dec_ddp    = dec_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=4, BLANK=1 (32-clock frames).
module tb_seg7_scan_driver;

    localparam int DIV   = 4;
    localparam int BLANK = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [47:0] d_in;
    logic [7:0]  an;
    logic [7:0]  dec_ddp;
    logic        frame_done;
    logic        pending;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    logic [7:0] walk_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] walk_dec [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1E};

    seg7_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .d_in       (d_in),
        .an         (an),
        .dec_ddp    (dec_ddp),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    function automatic logic [47:0] mk_word(input int mode);
        logic [47:0] w;
        logic [3:0]  h;
        logic        e;
        logic        p;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            case (mode)
                3: begin e = 1'b1; h = 4'(k);      p = (k == 7); end
                4: begin e = 1'b1; h = 4'(k + 2);  p = 1'b0; end
                5: begin e = 1'b1; h = 4'(15 - k); p = (k == 0); end
                6: begin e = (k % 2 == 0); h = 4'(k + 8); p = (k == 2); end
                default: begin e = 1'b1; h = 4'(3 * k); p = (k % 2 == 1); end
            endcase
            w[6*k +: 6] = {e, h, p};
        end
        return w;
    endfunction

    // j = negedge samples since the previous frame_done sample (1..32); output reflects scan state j-1.
    task automatic chk_cycle(input logic [47:0] word, input int j, input logic pend_exp);
        int         s;
        int         slot;
        int         dv;
        logic [5:0] dig;
        logic [7:0] ea;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
        s    = j - 1;
        slot = s / DIV;
        dv   = s % DIV;
        dig  = word[6*slot +: 6];
        if (dv < BLANK || !dig[5]) begin
            ea = 8'hFF;
            ed = 8'hFF;
        end else begin
            ea = ~(8'h01 << slot);
            ed = {seg_tab[dig[4:1]], ~dig[0]};
        end
        ep = pend_exp && (j != 32);
        ef = (j == 32);
        n_cmp++;
        if (an !== ea) begin
            n_bad++;
            $display("FAIL frame_an j=%0d got %h want %h", j, an, ea);
        end
        n_cmp++;
        if (dec_ddp !== ed) begin
            n_bad++;
            $display("FAIL frame_dec j=%0d got %h want %h", j, dec_ddp, ed);
        end
        n_cmp++;
        if (frame_done !== ef) begin
            n_bad++;
            $display("FAIL frame_done j=%0d got %b want %b", j, frame_done, ef);
        end
        n_cmp++;
        if (pending !== ep) begin
            n_bad++;
            $display("FAIL pending j=%0d got %b want %b", j, pending, ep);
        end
    endtask

    task automatic check_frame(input logic [47:0] word, input logic pend_exp);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            load = 1'b0;
            chk_cycle(word, j, pend_exp);
        end
    endtask

    // Called with rst just released at a negedge; first frame_done is 34 samples later
    // (2 sync clocks + 32 scan clocks), with the display dark and nothing pending.
    task automatic release_and_sync();
        int   found;
        logic dark_bad;
        found    = 0;
        dark_bad = 1'b0;
        for (int n = 1; n <= 100 && found == 0; n++) begin
            @(negedge clk);
            if (an !== 8'hFF || dec_ddp !== 8'hFF || pending !== 1'b0) dark_bad = 1'b1;
            if (frame_done === 1'b1) found = n;
        end
        n_cmp++;
        if (found != 34) begin
            n_bad++;
            $display("FAIL first_frame_done sample got %0d want 34", found);
        end
        n_cmp++;
        if (dark_bad !== 1'b0) begin
            n_bad++;
            $display("FAIL dark_after_reset got %b want 0", dark_bad);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        load = 1'b1;
        d_in = '1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (an !== 8'hFF) begin n_bad++; $display("FAIL reset_an got %h want ff", an); end
        n_cmp++;
        if (dec_ddp !== 8'hFF) begin n_bad++; $display("FAIL reset_dec got %h want ff", dec_ddp); end
        n_cmp++;
        if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd got %b want 0", frame_done); end
        n_cmp++;
        if (pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got %b want 0", pending); end
        load = 1'b0;
        d_in = '0;
        rst  = 1'b1;
        release_and_sync();
    endtask

    task automatic test_single_digit();
        logic lit;
        load = 1'b1;
        d_in = 48'h26;
        check_frame(48'h0, 1'b1);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            lit = (j >= 2 && j <= 4);
            n_cmp++;
            if (an !== (lit ? 8'hFE : 8'hFF)) begin
                n_bad++;
                $display("FAIL single_an j=%0d got %h want %h", j, an, lit ? 8'hFE : 8'hFF);
            end
            n_cmp++;
            if (dec_ddp !== (lit ? 8'h0D : 8'hFF)) begin
                n_bad++;
                $display("FAIL single_dec j=%0d got %h want %h", j, dec_ddp, lit ? 8'h0D : 8'hFF);
            end
            n_cmp++;
            if (frame_done !== (j == 32)) begin
                n_bad++;
                $display("FAIL single_fd j=%0d got %b want %b", j, frame_done, (j == 32));
            end
        end
    endtask

    task automatic test_walk();
        int slot;
        logic lit;
        load = 1'b1;
        d_in = mk_word(3);
        check_frame(48'h26, 1'b1);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            slot = (j - 1) / DIV;
            lit  = ((j - 1) % DIV) != 0;
            n_cmp++;
            if (an !== (lit ? walk_an[slot] : 8'hFF)) begin
                n_bad++;
                $display("FAIL walk_an j=%0d got %h want %h", j, an, lit ? walk_an[slot] : 8'hFF);
            end
            n_cmp++;
            if (dec_ddp !== (lit ? walk_dec[slot] : 8'hFF)) begin
                n_bad++;
                $display("FAIL walk_dec j=%0d got %h want %h", j, dec_ddp, lit ? walk_dec[slot] : 8'hFF);
            end
        end
    endtask

    task automatic test_back_to_back();
        load = 1'b1;
        d_in = mk_word(4);
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            load = 1'b0;
            if (j == 5) begin
                load = 1'b1;
                d_in = mk_word(5);
            end
            chk_cycle(mk_word(3), j, 1'b1);
        end
        check_frame(mk_word(5), 1'b0);
    endtask

    task automatic test_load_at_frame_end();
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            load = 1'b0;
            if (j == 31) begin
                load = 1'b1;
                d_in = mk_word(7);
            end
            chk_cycle(mk_word(5), j, 1'b0);
        end
        check_frame(mk_word(7), 1'b0);
    endtask

    task automatic test_enable_mask();
        logic [7:0] seen_low;
        load = 1'b1;
        d_in = mk_word(6);
        check_frame(mk_word(7), 1'b1);
        seen_low = '0;
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            seen_low = seen_low | (~an & 8'hAA);
            chk_cycle(mk_word(6), j, 1'b0);
        end
        n_cmp++;
        if (seen_low !== 8'h00) begin
            n_bad++;
            $display("FAIL disabled_anodes got %h want 00", seen_low);
        end
    endtask

    task automatic test_mid_reset();
        load = 1'b1;
        d_in = mk_word(3);
        repeat (3) begin
            @(negedge clk);
            load = 1'b0;
        end
        n_cmp++;
        if (an !== 8'hFE || dec_ddp !== 8'h01 || pending !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset got an=%h dec=%h pend=%b want fe 01 1", an, dec_ddp, pending);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (an !== 8'hFF) begin n_bad++; $display("FAIL midrst_an got %h want ff", an); end
        n_cmp++;
        if (dec_ddp !== 8'hFF) begin n_bad++; $display("FAIL midrst_dec got %h want ff", dec_ddp); end
        n_cmp++;
        if (pending !== 1'b0) begin n_bad++; $display("FAIL midrst_pending got %b want 0", pending); end
        n_cmp++;
        if (frame_done !== 1'b0) begin n_bad++; $display("FAIL midrst_fd got %b want 0", frame_done); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        release_and_sync();
        check_frame(48'h0, 1'b0);
    endtask

    initial begin
        rst  = 1'b0;
        load = 1'b0;
        d_in = '0;
        test_reset();
        test_single_digit();
        test_walk();
        test_back_to_back();
        test_load_at_frame_end();
        test_enable_mask();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
